// File: rtl/benes_cfg_loader.sv
// -----------------------------------------------------------------------------
// benes_cfg_loader
//
// Configuration writer for the Benes permutation network. Per-stage switch
// words arrive over a valid/ready write port and land in the shadow half of a
// double-buffered register bank. A commit swaps the shadow and active halves.
// Each stage's bank select is delayed by its stage index, so a data vector
// walking the stage chain sees one consistent configuration even across a
// commit.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   cfg_valid     write request
//   cfg_ready     shadow bank writable (low while the old bank drains)
//   cfg_stage     target stage index for the write
//   cfg_word      switch bits for that stage; bit i drives switch i
//   cfg_err       one-cycle pulse after an accepted write with a bad stage index
//   commit_valid  request to swap shadow and active banks
//   commit_ready  every shadow stage rewritten since the last commit, not draining
//   active_bank   current active bank pointer
//   switch_set    per-stage switch controls to the stage modules
// -----------------------------------------------------------------------------
module benes_cfg_loader #(
    parameter int SIZE       = 32,
    parameter int SWITCH_NUM = SIZE / 2,
    parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
    parameter int STAGE_W    = $clog2(STAGE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [STAGE_W-1:0]    cfg_stage,
    input  logic [SWITCH_NUM-1:0] cfg_word,
    output logic                  cfg_err,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    output logic                  active_bank,
    output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1]
);

    logic [SWITCH_NUM-1:0] bank [0:1][0:STAGE_NUM-1];
    logic                  act;
    logic [STAGE_NUM-1:1]  sel_pipe;
    logic [STAGE_NUM-1:0]  wr_mask;
    logic [STAGE_NUM-1:0]  wr_hit;
    logic [STAGE_NUM-1:0]  stage_sel;
    logic [STAGE_W-1:0]    drain;
    logic                  wr_accept;
    logic                  wr_bad;
    logic                  commit_accept;

    // Ready flags depend only on registered state, never on the valid inputs.
    assign cfg_ready     = (drain == '0);
    assign commit_ready  = (&wr_mask) && cfg_ready;
    assign active_bank   = act;
    assign wr_accept     = cfg_valid && cfg_ready;
    assign commit_accept = commit_valid && commit_ready;

    // One-hot decode of the write target; an index past the last stage hits
    // nothing, which is exactly the error condition.
    always_comb begin
        wr_hit = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            wr_hit[s] = wr_accept && (cfg_stage == STAGE_W'(s));
        end
    end

    assign wr_bad = wr_accept && (wr_hit == '0);

    // Stage 0 follows the pointer directly; stage k follows it k cycles late,
    // matching the time a vector needs to reach that stage.
    assign stage_sel = {sel_pipe, act};

    // NOTE: the bank is reset, not left uninitialised, because all-zero is the
    // pass-through configuration the network must come up in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    bank[b][s] <= '0;
                end
            end
        end else begin
            // NOTE: act here is the pre-edge value, so a write in the commit
            // cycle lands in the bank that is about to become active.
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (wr_hit[s]) begin
                    bank[~act][s] <= cfg_word;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act      <= 1'b0;
            sel_pipe <= '0;
            wr_mask  <= '0;
            drain    <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err  <= wr_bad;
            sel_pipe <= {sel_pipe[STAGE_NUM-2:1], act};
            if (commit_accept) begin
                act     <= ~act;
                wr_mask <= '0;
                // The old bank stays frozen until the last stage stops reading it.
                drain   <= STAGE_W'(STAGE_NUM - 2);
            end else begin
                wr_mask <= wr_mask | wr_hit;
                if (drain != '0) begin
                    drain <= drain - STAGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGE_NUM; k++) begin
            switch_set[k] = bank[stage_sel[k]][k];
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
module tb_benes_cfg_loader;

    localparam int SN = 9;   // stages for SIZE=32
    localparam int SW = 16;  // switches per stage

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_stage;
    logic [SW-1:0] cfg_word;
    logic          cfg_err;
    logic          commit_valid;
    logic          commit_ready;
    logic          active_bank;
    logic [SW-1:0] switch_set [0:SN-1];

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] old_cfg  [SN];
    logic [SW-1:0] new_cfg  [SN];
    logic [SW-1:0] next_cfg [SN];

    typedef struct {
        logic          v;
        logic [3:0]    stage;
        logic [SW-1:0] word;
        logic          cv;
        logic          e_ready;
        logic          e_cready;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];

    benes_cfg_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_stage    (cfg_stage),
        .cfg_word     (cfg_word),
        .cfg_err      (cfg_err),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .active_bank  (active_bank),
        .switch_set   (switch_set)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [SW-1:0] w, input logic cv);
        cfg_valid    = v;
        cfg_stage    = s;
        cfg_word     = w;
        commit_valid = cv;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < SN; k++) begin
            check($sformatf("%s_sw%0d", tag, k), switch_set[k], 0);
        end
    endtask

    // Called right after a commit has been driven in cycle t; checks cycles
    // t+1..t+10. Optionally keeps a write of next_cfg pending from t+1 onward.
    task automatic commit_window(input string tag, input logic exp_ab, input bit refill);
        for (int j = 1; j <= 10; j++) begin
            int s;
            @(negedge clk);
            check($sformatf("%s_j%0d_active_bank", tag, j), active_bank, exp_ab);
            check($sformatf("%s_j%0d_cfg_ready", tag, j), cfg_ready, (j >= 8));
            check($sformatf("%s_j%0d_commit_ready", tag, j), commit_ready, 0);
            check($sformatf("%s_j%0d_cfg_err", tag, j), cfg_err, 0);
            for (int k = 0; k < SN; k++) begin
                check($sformatf("%s_j%0d_sw%0d", tag, j, k), switch_set[k],
                      (j >= k + 1) ? new_cfg[k] : old_cfg[k]);
            end
            if (refill) begin
                s = (j <= 8) ? 0 : j - 8;
                drive(1'b1, 4'(s), next_cfg[s], 1'b0);
            end else begin
                drive(1'b0, 4'd0, '0, 1'b0);
            end
        end
    endtask

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        drive(1'b0, 4'd0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_commit_ready", commit_ready, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_active_bank", active_bank, 0);
        check_all_zero("rst");

        // Partial fill, ignored commit, bad index, completion, rewrite.
        for (int s = 0; s < 8; s++) begin
            vecs.push_back('{1'b1, 4'(s), 16'hFFFF ^ 16'(s), 1'b0, 1'b1, 1'b0, 1'b0});
        end
        vecs.push_back('{1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}); // commit ignored
        vecs.push_back('{1'b1, 4'd9,  16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1}); // bad index
        vecs.push_back('{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}); // err ends
        vecs.push_back('{1'b1, 4'd8,  16'hFFF7, 1'b0, 1'b1, 1'b1, 1'b0}); // mask full
        vecs.push_back('{1'b1, 4'd5,  16'h1234, 1'b0, 1'b1, 1'b1, 1'b0}); // rewrite
        vecs.push_back('{1'b1, 4'd5,  16'hFFFA, 1'b0, 1'b1, 1'b1, 1'b0}); // last wins
        vecs.push_back('{1'b1, 4'd15, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1}); // bad, mask kept
        vecs.push_back('{1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].stage, vecs[i].word, vecs[i].cv);
            @(negedge clk);
            check($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_commit_ready", i), commit_ready, vecs[i].e_cready);
            check($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].e_err);
            check($sformatf("vec%0d_active_bank", i), active_bank, 0);
        end
        check_all_zero("prefill");

        // First commit with refill held against the drain.
        for (int k = 0; k < SN; k++) begin
            old_cfg[k]  = '0;
            new_cfg[k]  = 16'hFFFF ^ 16'(k);
            next_cfg[k] = 16'h3C00 | 16'(k);
        end
        drive(1'b0, 4'd0, '0, 1'b1);
        commit_window("c1", 1'b1, 1'b1);
        for (int s = 3; s < SN; s++) begin
            @(negedge clk);
            check($sformatf("refill%0d_cfg_ready", s), cfg_ready, 1);
            check($sformatf("refill%0d_commit_ready", s), commit_ready, 0);
            drive(1'b1, 4'(s), next_cfg[s], 1'b0);
        end
        @(negedge clk);
        check("refill_done_commit_ready", commit_ready, 1);

        // Second commit with a same-cycle write to stage 3.
        for (int k = 0; k < SN; k++) begin
            old_cfg[k] = new_cfg[k];
            new_cfg[k] = next_cfg[k];
        end
        new_cfg[3] = 16'hA5A5;
        drive(1'b1, 4'd3, 16'hA5A5, 1'b1);
        commit_window("c2", 1'b0, 1'b0);

        // Third commit, then asynchronous reset in the middle of the drain.
        for (int s = 0; s < SN; s++) begin
            drive(1'b1, 4'(s), 16'h7700 | 16'(s), 1'b0);
            @(negedge clk);
        end
        check("c3_commit_ready", commit_ready, 1);
        drive(1'b0, 4'd0, '0, 1'b1);
        @(negedge clk);
        check("c3_active_bank", active_bank, 1);
        drive(1'b0, 4'd0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("c3_mid_drain_cfg_ready", cfg_ready, 0);
        check("c3_mid_drain_sw0", switch_set[0], 16'h7700);
        #2 rst = 1'b1;
        #1;
        check("async_rst_active_bank", active_bank, 0);
        check("async_rst_cfg_ready", cfg_ready, 1);
        check("async_rst_commit_ready", commit_ready, 0);
        check("async_rst_cfg_err", cfg_err, 0);
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_ready", cfg_ready, 1);
        check("post_rst_commit_ready", commit_ready, 0);
        check("post_rst_sw8", switch_set[8], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
